// File: rtl/tdc_pair_sched.sv
// rtl/tdc_pair_sched.sv - pairs same-channel TDC samples and schedules a shared pair-sum adder
module tdc_pair_sched #(
    parameter int DW  = 37,
    parameter int OW  = 20,
    parameter int GAP = 4,
    parameter int CW  = 8
) (
    input  logic          clk,
    input  logic          rst,
    input  logic [OW-1:0] cfg_offset,
    input  logic [15:0]   cfg_timeout,
    input  logic          ch0_dval,
    input  logic [DW-1:0] ch0_data,
    input  logic          ch1_dval,
    input  logic [DW-1:0] ch1_data,
    output logic [OW-1:0] out_data,
    output logic          out_ch,
    output logic          o_dval,
    output logic          busy,
    output logic [CW-1:0] ovf_cnt,
    output logic [CW-1:0] tmo_cnt
);

    typedef enum logic [1:0] {B_EMPTY, B_HALF, B_FULL} buf_t;
    typedef enum logic [1:0] {S_IDLE, S_SUM, S_OUT, S_GAP} state_t;

    state_t        r_state, w_next;
    buf_t          r_bst  [2];
    logic [DW-1:0] r_a    [2];
    logic [DW-1:0] r_b    [2];
    logic [15:0]   r_wait [2];
    logic          r_rr;
    logic [DW-1:0] r_opa, r_opb;
    logic [OW-1:0] r_off;
    logic          r_ch;
    logic [OW-1:0] r_sum;
    logic [15:0]   r_gcnt;

    logic          w_dval [2];
    logic [DW-1:0] w_data [2];
    logic          w_gnt  [2];
    logic          w_ovf  [2];
    logic          w_tmo  [2];
    logic          w_full0, w_full1, w_gnt_any, w_gnt_ch;
    logic [CW:0]   w_ovf_sum, w_tmo_sum;

    always_comb begin
        w_dval[0] = ch0_dval;
        w_dval[1] = ch1_dval;
        w_data[0] = ch0_data;
        w_data[1] = ch1_data;
        w_full0   = (r_bst[0] == B_FULL);
        w_full1   = (r_bst[1] == B_FULL);
        w_gnt_any = (r_state == S_IDLE) && (w_full0 || w_full1);
        // round-robin only arbitrates when both channels hold a complete pair
        w_gnt_ch  = (w_full0 && w_full1) ? r_rr : w_full1;
        w_gnt[0]  = w_gnt_any && !w_gnt_ch;
        w_gnt[1]  = w_gnt_any && w_gnt_ch;
        for (int c = 0; c < 2; c++) begin
            w_ovf[c] = w_dval[c] && (r_bst[c] == B_FULL) && !w_gnt[c];
            w_tmo[c] = (r_bst[c] == B_HALF) && !w_dval[c] && (cfg_timeout != 16'd0)
                       && ((r_wait[c] + 16'd1) == cfg_timeout);
        end
        w_ovf_sum = {1'b0, ovf_cnt} + {{CW{1'b0}}, w_ovf[0]} + {{CW{1'b0}}, w_ovf[1]};
        w_tmo_sum = {1'b0, tmo_cnt} + {{CW{1'b0}}, w_tmo[0]} + {{CW{1'b0}}, w_tmo[1]};
    end

    always_ff @(posedge clk) begin
        for (int c = 0; c < 2; c++) begin
            if (rst) begin
                r_bst[c]  <= B_EMPTY;
                r_a[c]    <= '0;
                r_b[c]    <= '0;
                r_wait[c] <= '0;
            end else begin
                case (r_bst[c])
                    B_EMPTY: if (w_dval[c]) begin
                        r_a[c]    <= w_data[c];
                        r_wait[c] <= '0;
                        r_bst[c]  <= B_HALF;
                    end
                    B_HALF: if (w_dval[c]) begin
                        r_b[c]   <= w_data[c];
                        r_bst[c] <= B_FULL;
                    end else if (w_tmo[c]) begin
                        r_bst[c] <= B_EMPTY;
                    end else if (cfg_timeout != 16'd0) begin
                        r_wait[c] <= r_wait[c] + 16'd1;
                    end
                    B_FULL: if (w_gnt[c]) begin
                        if (w_dval[c]) begin
                            r_a[c]    <= w_data[c];
                            r_wait[c] <= '0;
                            r_bst[c]  <= B_HALF;
                        end else begin
                            r_bst[c] <= B_EMPTY;
                        end
                    end
                    default: r_bst[c] <= B_EMPTY;
                endcase
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) r_state <= S_IDLE;
        else     r_state <= w_next;
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE: if (w_gnt_any) w_next = S_SUM;
            S_SUM:  w_next = S_OUT;
            S_OUT:  w_next = (GAP == 0) ? S_IDLE : S_GAP;
            S_GAP:  if (r_gcnt == 16'(GAP - 1)) w_next = S_IDLE;
            default: w_next = S_IDLE;
        endcase
    end

    assign busy = (r_state != S_IDLE);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_rr     <= 1'b0;
            r_opa    <= '0;
            r_opb    <= '0;
            r_off    <= '0;
            r_ch     <= 1'b0;
            r_sum    <= '0;
            r_gcnt   <= '0;
            out_data <= '0;
            out_ch   <= 1'b0;
            o_dval   <= 1'b0;
            ovf_cnt  <= '0;
            tmo_cnt  <= '0;
        end else begin
            if (w_gnt_any) begin
                r_opa <= r_a[w_gnt_ch];
                r_opb <= r_b[w_gnt_ch];
                r_off <= cfg_offset;
                r_ch  <= w_gnt_ch;
                if (w_full0 && w_full1) r_rr <= ~r_rr;
            end
            if (r_state == S_SUM)
                r_sum <= OW'({1'b0, r_opa} + {1'b0, r_opb} + {{(DW + 1 - OW){1'b0}}, r_off});
            o_dval <= (r_state == S_OUT);
            if (r_state == S_OUT) begin
                out_data <= r_sum;
                out_ch   <= r_ch;
            end
            r_gcnt  <= (r_state == S_GAP) ? r_gcnt + 16'd1 : 16'd0;
            ovf_cnt <= w_ovf_sum[CW] ? '1 : w_ovf_sum[CW-1:0];
            tmo_cnt <= w_tmo_sum[CW] ? '1 : w_tmo_sum[CW-1:0];
        end
    end

endmodule
